fp16_argmax: RTL and testbench

Sequential arg-max stage that sits directly downstream of the fp16 softmax block. It captures the IN_OUT_NUM-element fp16 probability vector when the softmax asserts valid. It then scans one element per cycle and reports the index and value of the largest element as the network's classification result. It pairs with the softmax 1:1: the softmax `output_neuron_val` and `valid` connect straight to this block's `input_neuron_val` and `start_op`.

---
 rtl/fp16_argmax.sv | 145 ++++++++++++++
 tb/tb_fp16_argmax.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_argmax.sv
`default_nettype none
// ============================================================================
// Module      : fp16_argmax
// Description : Sequential arg-max over an IN_OUT_NUM-element fp16 vector.
//               Captures the vector on start_op, scans one element per cycle
//               and reports the index and value of the largest element.
//               Optional macro FP16_ARGMAX_NAN_SKIP_EN: when defined, NaN
//               elements never win the comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_argmax #(
    parameter int IN_OUT_NUM = 10,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset_b,
    input  logic                     start_op,
    input  logic                     clear,
    input  logic [IN_OUT_NUM*16-1:0] input_neuron_val,
    output logic [IDX_WIDTH-1:0]     max_index,
    output logic [15:0]              max_value,
    output logic                     valid,
    output logic                     busy
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SCAN = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [IDX_WIDTH-1:0] c_LAST = IDX_WIDTH'(IN_OUT_NUM - 1);
    localparam logic [IDX_WIDTH-1:0] c_ONE  = IDX_WIDTH'(1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [15:0]          r_buf [IN_OUT_NUM];
    logic [IDX_WIDTH-1:0] r_cnt;
    logic [IDX_WIDTH-1:0] r_best_idx;
    logic [15:0]          r_best_val;
    logic                 w_abort;
    logic                 w_accept;
    logic                 w_take;
    logic [15:0]          w_cand;

    // Monotonic unsigned key: -inf < negatives < +-0 < positives < +inf.
    // Negative zero is folded onto positive zero so both compare equal.
    function automatic logic [15:0] f_key(input logic [15:0] x);
        logic [15:0] v;
        v = (x == 16'h8000) ? 16'h0000 : x;
        return v[15] ? ~v : {1'b1, v[14:0]};
    endfunction

`ifdef FP16_ARGMAX_NAN_SKIP_EN
    function automatic logic f_is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction
`endif

    // Reset and clear share one abort path; clear outranks start_op.
    assign w_abort  = reset_b | clear;
    assign w_accept = start_op && (r_state == c_ST_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (w_abort) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start_op outside IDLE has no effect.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start_op) begin
                    w_state_nxt = (IN_OUT_NUM > 1) ? c_ST_SCAN : c_ST_DONE;
                end
            end
            c_ST_SCAN: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state only.
    always_comb begin
        busy  = (r_state != c_ST_IDLE);
        valid = (r_state == c_ST_DONE);
    end

    // Select the captured element addressed by the compare counter.
    always_comb begin
        w_cand = 16'h0000;
        for (int k = 0; k < IN_OUT_NUM; k++) begin
            if (r_cnt == IDX_WIDTH'(k)) begin
                w_cand = r_buf[k];
            end
        end
    end

`ifdef FP16_ARGMAX_NAN_SKIP_EN
    // A NaN candidate never wins; a NaN incumbent (only possible for
    // element 0) loses to the first non-NaN candidate.
    assign w_take = !f_is_nan(w_cand) &&
                    (f_is_nan(r_best_val) || (f_key(w_cand) > f_key(r_best_val)));
`else
    // Strictly greater replaces, so ties keep the lower index.
    assign w_take = f_key(w_cand) > f_key(r_best_val);
`endif

    // Capture buffer, compare counter and best-so-far registers.
    always_ff @(posedge clk) begin
        if (w_abort) begin
            for (int k = 0; k < IN_OUT_NUM; k++) begin
                r_buf[k] <= 16'h0000;
            end
            r_cnt      <= '0;
            r_best_idx <= '0;
            r_best_val <= 16'h0000;
        end else if (w_accept) begin
            for (int k = 0; k < IN_OUT_NUM; k++) begin
                r_buf[k] <= input_neuron_val[k*16 +: 16];
            end
            r_best_val <= input_neuron_val[15:0];
            r_best_idx <= '0;
            r_cnt      <= c_ONE;
        end else if (r_state == c_ST_SCAN) begin
            if (w_take) begin
                r_best_val <= w_cand;
                r_best_idx <= r_cnt;
            end
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign max_index = r_best_idx;
    assign max_value = r_best_val;

endmodule
`default_nettype wire

// File: tb/tb_fp16_argmax.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp16_argmax
// Description : Self-checking bench for fp16_argmax with a value-based
//               reference model (fp16 decoded to scaled integers).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_argmax;

    localparam int N  = 10;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            reset_b;
    logic            start_op;
    logic            clear;
    logic [N*16-1:0] vin;
    logic [IW-1:0]   max_index;
    logic [15:0]     max_value;
    logic            valid;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp16_argmax #(.IN_OUT_NUM(N), .IDX_WIDTH(IW)) dut (
        .clk              (clk),
        .reset_b          (reset_b),
        .start_op         (start_op),
        .clear            (clear),
        .input_neuron_val (vin),
        .max_index        (max_index),
        .max_value        (max_value),
        .valid            (valid),
        .busy             (busy)
    );

    // fp16 value scaled by 2^25 as a signed integer; inf and NaN placed above
    // every finite value, NaNs ordered by mantissa.
    function automatic longint f_val(input logic [15:0] x);
        longint m;
        int     e;
        longint mag;
        m = longint'(x[9:0]);
        e = int'(x[14:10]);
        if (e == 0)       mag = 2 * m;
        else if (e == 31) mag = (m == 0) ? (longint'(1) << 50) : (longint'(1) << 51) + m;
        else              mag = (1024 + m) << e;
        return x[15] ? -mag : mag;
    endfunction

    function automatic logic f_is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction

    // Reference: first element holding the maximum value.
    task automatic ref_argmax(input logic [N*16-1:0] v, output int idx, output logic [15:0] val);
        logic [15:0] e;
        logic        found;
        idx   = 0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            e = v[k*16 +: 16];
`ifdef FP16_ARGMAX_NAN_SKIP_EN
            if (f_is_nan(e)) continue;
`endif
            if (!found || f_val(e) > f_val(v[idx*16 +: 16])) begin
                idx   = k;
                found = 1'b1;
            end
        end
        val = v[idx*16 +: 16];
    endtask

    function automatic logic [15:0] rand_elem();
        case ($urandom_range(0, 9))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h3C00;
            3: return 16'hBC00;
            4: return 16'h7C00;
            5: return 16'hFC00;
            6: return 16'h7E00;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [N*16-1:0] rand_vec();
        logic [N*16-1:0] v;
        for (int k = 0; k < N; k++) v[k*16 +: 16] = rand_elem();
        return v;
    endfunction

    function automatic logic [N*16-1:0] fill(input logic [15:0] base);
        logic [N*16-1:0] v;
        for (int k = 0; k < N; k++) v[k*16 +: 16] = base;
        return v;
    endfunction

    // Start a scan in cycle 0 and record busy/valid for cycles 1..N+1 plus
    // the outputs seen while valid; returns at cycle N+1.
    task automatic run_scan(input logic [N*16-1:0] v, output logic [31:0] bmask,
                            output logic [31:0] vmask, output logic [IW-1:0] idx,
                            output logic [15:0] val);
        bmask = '0;
        vmask = '0;
        idx   = 'x;
        val   = 'x;
        @(negedge clk);
        vin      = v;
        start_op = 1'b1;
        for (int c = 1; c <= N + 1; c++) begin
            @(negedge clk);
            start_op = 1'b0;
            vin      = rand_vec();
            bmask[c] = busy;
            vmask[c] = valid;
            if (valid) begin
                idx = max_index;
                val = max_value;
            end
        end
    endtask

    localparam logic [31:0] c_EXP_B = (32'd1 << (N + 1)) - 32'd2;
    localparam logic [31:0] c_EXP_V = 32'd1 << N;

    task automatic test_reset();
        @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        reset_b = 1'b0;
        checks++; if (max_index !== '0) begin failures++; $display("FAIL reset_index: got %0d expected 0", max_index); end
        checks++; if (max_value !== 16'h0000) begin failures++; $display("FAIL reset_value: got %h expected 0000", max_value); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        // Reset mid-scan returns everything to zero.
        vin = fill(16'h3C00);
        vin[9*16 +: 16] = 16'h4000;
        start_op = 1'b1;
        repeat (7) begin
            @(negedge clk);
            start_op = 1'b0;
        end
        reset_b = 1'b1;
        @(negedge clk);
        reset_b = 1'b0;
        checks++; if ({busy, valid, max_index, max_value} !== '0) begin failures++;
            $display("FAIL midscan_reset: got busy=%b valid=%b idx=%0d val=%h expected all zero", busy, valid, max_index, max_value); end
    endtask

    task automatic test_directed();
        logic [N*16-1:0] v;
        logic [31:0]     bm, vm;
        logic [IW-1:0]   idx, exp_idx;
        logic [15:0]     val, exp_val;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin v = fill(16'h2266); v[3*16 +: 16] = 16'h2E66; v[7*16 +: 16] = 16'h3A66; exp_idx = 4'd7; exp_val = 16'h3A66; end
                1: begin v = fill(16'h3800); v[2*16 +: 16] = 16'h3C00; v[5*16 +: 16] = 16'h3C00; exp_idx = 4'd2; exp_val = 16'h3C00; end
                2: begin v = fill(16'h8000); v[4*16 +: 16] = 16'h0000; exp_idx = 4'd0; exp_val = 16'h8000; end
                3: begin v = fill(16'hC000); v[6*16 +: 16] = 16'hBC00; exp_idx = 4'd6; exp_val = 16'hBC00; end
                default: begin v = fill(16'h7BFF); v[9*16 +: 16] = 16'h7C00; exp_idx = 4'd9; exp_val = 16'h7C00; end
            endcase
            run_scan(v, bm, vm, idx, val);
            checks++; if (bm !== c_EXP_B) begin failures++; $display("FAIL dir%0d_busy_cycles: got %h expected %h", i, bm, c_EXP_B); end
            checks++; if (vm !== c_EXP_V) begin failures++; $display("FAIL dir%0d_valid_cycles: got %h expected %h", i, vm, c_EXP_V); end
            checks++; if (idx !== exp_idx) begin failures++; $display("FAIL dir%0d_index: got %0d expected %0d", i, idx, exp_idx); end
            checks++; if (val !== exp_val) begin failures++; $display("FAIL dir%0d_value: got %h expected %h", i, val, exp_val); end
            checks++; if (max_index !== exp_idx || max_value !== exp_val) begin failures++;
                $display("FAIL dir%0d_hold: got %0d/%h expected %0d/%h", i, max_index, max_value, exp_idx, exp_val); end
        end
    endtask

    task automatic test_nan();
        logic [N*16-1:0] v;
        logic [31:0]     bm, vm;
        logic [IW-1:0]   idx, exp_idx;
        logic [15:0]     val;
        int              ridx;
        logic [15:0]     rval;
        v = fill(16'h3800);
        v[1*16 +: 16] = 16'h7E00;
        v[8*16 +: 16] = 16'h3C00;
`ifdef FP16_ARGMAX_NAN_SKIP_EN
        exp_idx = 4'd8;
`else
        exp_idx = 4'd1;
`endif
        run_scan(v, bm, vm, idx, val);
        checks++; if (idx !== exp_idx) begin failures++; $display("FAIL nan_index: got %0d expected %0d", idx, exp_idx); end
        // NaN at element 0 followed by finite values, then an all-NaN vector.
        for (int i = 0; i < 2; i++) begin
            v = (i == 0) ? fill(16'hC000) : fill(16'hFE01);
            v[0] = 1'b1; // keep the pattern varied without changing class
            v[0*16 +: 16] = 16'h7E00;
            if (i == 0) v[5*16 +: 16] = 16'hB800;
            ref_argmax(v, ridx, rval);
            run_scan(v, bm, vm, idx, val);
            checks++; if (idx !== IW'(ridx) || val !== rval) begin failures++;
                $display("FAIL nan_case%0d: got %0d/%h expected %0d/%h", i, idx, val, ridx, rval); end
        end
    endtask

    task automatic test_random();
        logic [N*16-1:0] v;
        logic [31:0]     bm, vm;
        logic [IW-1:0]   idx;
        logic [15:0]     val;
        int              ridx;
        logic [15:0]     rval;
        for (int i = 0; i < 30; i++) begin
            v = rand_vec();
            ref_argmax(v, ridx, rval);
            run_scan(v, bm, vm, idx, val);
            checks++; if (vm !== c_EXP_V) begin failures++; $display("FAIL rand%0d_valid_cycles: got %h expected %h", i, vm, c_EXP_V); end
            checks++; if (idx !== IW'(ridx) || val !== rval) begin failures++;
                $display("FAIL rand%0d_result: got %0d/%h expected %0d/%h vec=%h", i, idx, val, ridx, rval, v); end
        end
    endtask

    task automatic test_back_to_back();
        logic [N*16-1:0] va, vb;
        int              ia, ib;
        logic [15:0]     vala, valb;
        logic [31:0]     bm, vm, exp_b, exp_v;
        logic [IW-1:0]   ga, gb;
        logic [15:0]     gva, gvb;
        va = fill(16'h3400);
        va[2*16 +: 16] = 16'h3800;
        vb = rand_vec();
        vb[8*16 +: 16] = 16'h7C00;
        vb[9*16 +: 16] = 16'h7E01;
        ref_argmax(va, ia, vala);
        ref_argmax(vb, ib, valb);
        bm = '0; vm = '0;
        ga = 'x; gb = 'x; gva = 'x; gvb = 'x;
        exp_b = c_EXP_B | (c_EXP_B << (N + 1));
        exp_v = c_EXP_V | (c_EXP_V << (N + 1));
        @(negedge clk);
        vin      = va;
        start_op = 1'b1;
        for (int c = 1; c <= 2 * N + 2; c++) begin
            @(negedge clk);
            start_op = 1'b0;
            bm[c] = busy;
            vm[c] = valid;
            if (c == N) begin ga = max_index; gva = max_value; end
            if (c == 2 * N + 1) begin gb = max_index; gvb = max_value; end
            if (c == 5 || c == N + 1) begin
                vin      = vb;
                start_op = 1'b1;
            end
        end
        checks++; if (bm !== exp_b) begin failures++; $display("FAIL b2b_busy_cycles: got %h expected %h", bm, exp_b); end
        checks++; if (vm !== exp_v) begin failures++; $display("FAIL b2b_valid_cycles: got %h expected %h", vm, exp_v); end
        checks++; if (ga !== IW'(ia) || gva !== vala) begin failures++;
            $display("FAIL b2b_first_result: got %0d/%h expected %0d/%h", ga, gva, ia, vala); end
        checks++; if (gb !== IW'(ib) || gvb !== valb) begin failures++;
            $display("FAIL b2b_second_result: got %0d/%h expected %0d/%h", gb, gvb, ib, valb); end
    endtask

    task automatic test_clear();
        logic [N*16-1:0] v;
        logic [31:0]     vm;
        for (int k = 0; k < N; k++) v[k*16 +: 16] = 16'h3C00 + 16'(k);
        vm = '0;
        @(negedge clk);
        vin      = v;
        start_op = 1'b1;
        for (int c = 1; c <= N + 2; c++) begin
            @(negedge clk);
            start_op = 1'b0;
            clear    = 1'b0;
            vm[c]    = valid;
            if (c == 5) begin
                checks++; if ({busy, max_index, max_value} !== '0) begin failures++;
                    $display("FAIL clear_abort: got busy=%b idx=%0d val=%h expected all zero", busy, max_index, max_value); end
            end
            if (c == 4) clear = 1'b1;
        end
        checks++; if (vm !== '0) begin failures++; $display("FAIL clear_no_valid: got %h expected 0", vm); end
        // clear together with start_op: stays IDLE.
        vm = '0;
        @(negedge clk);
        vin      = v;
        start_op = 1'b1;
        clear    = 1'b1;
        @(negedge clk);
        start_op = 1'b0;
        clear    = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clear_start_busy: got %b expected 0", busy); end
        for (int c = 2; c <= N + 2; c++) begin
            @(negedge clk);
            vm[c] = valid | busy;
        end
        checks++; if (vm !== '0) begin failures++; $display("FAIL clear_start_idle: got %h expected 0", vm); end
    endtask

    initial begin
        reset_b  = 1'b1;
        start_op = 1'b0;
        clear    = 1'b0;
        vin      = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_directed();
        test_nan();
        test_random();
        test_back_to_back();
        test_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
